// File: rtl/spu_stream_sequencer_pkg.sv
// Shared types and helpers for the SPU stream sequencer.
package spu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } err_e;

    // Width of a counter that runs 0..bound-1 (drain timeout / flush length).
    function automatic int bound_width(input int bound);
        return (bound < 2) ? 1 : $clog2(bound);
    endfunction

endpackage

// File: rtl/spu_stream_sequencer_if.sv
// SRAM/SPU strobe bundle between the sequencer and the datapath around it.
interface spu_stream_sequencer_if #(
    parameter int ADDR_BITS = 10
) ();
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 spu_s_valid;
    logic                 spu_m_valid;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;

    modport master (
        output rd_en, rd_addr, spu_s_valid, wr_en, wr_addr,
        input  spu_m_valid
    );

    modport slave (
        input  rd_en, rd_addr, spu_s_valid, wr_en, wr_addr,
        output spu_m_valid
    );
endinterface

// File: rtl/spu_stream_sequencer_valid_delay.sv
// cke-gated valid delay line that aligns read strobes with SRAM read data.
module spu_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    input  logic clr,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q, sr_d;

    // Shift only on enabled cycles; a new pass wipes anything left in flight.
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (cke) begin
            sr_d    = sr_q << 1;
            sr_d[0] = din;
        end
    end

    // Delay line register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/spu_stream_sequencer.sv
// Sequences one SRAM -> SPU -> SRAM pass: issues reads, aligns SPU input
// valid to read latency, counts SPU results into write addresses, and
// reports completion, timeout or abort.
module spu_stream_sequencer
    import spu_seq_pkg::*;
#(
    parameter int ADDR_BITS      = 10,
    parameter int LEN_BITS       = 11,
    parameter int RD_LATENCY     = 1,
    parameter int SPU_LATENCY    = 256,
    parameter int TIMEOUT_MARGIN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] cfg_src_addr,
    input  logic [ADDR_BITS-1:0] cfg_dst_addr,
    input  logic [LEN_BITS-1:0]  cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           error,
    output logic [LEN_BITS-1:0]  wr_count,
    spu_stream_sequencer_if.master bus
);
    localparam int TO_BOUND = RD_LATENCY + SPU_LATENCY + TIMEOUT_MARGIN;
    localparam int FL_BOUND = RD_LATENCY + SPU_LATENCY;
    localparam int CNT_W    = bound_width(TO_BOUND);
    localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(TO_BOUND - 1);
    localparam logic [CNT_W-1:0]    FL_LAST = CNT_W'(FL_BOUND - 1);
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(2 ** ADDR_BITS);

    state_e                state_q, state_d;
    err_e                  err_q, err_d;
    logic [ADDR_BITS-1:0]  src_q, src_d, dst_q, dst_d;
    logic [LEN_BITS-1:0]   len_q, len_d, rd_idx_q, rd_idx_d, wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_acc, rd_en_c, wr_en_c, last_wr, dly_out;

    assign start_acc = cke && start && (state_q == ST_IDLE);
    assign rd_en_c   = cke && (state_q == ST_READ);
    // Write strobe is combinational from the SPU output valid; FLUSH/IDLE/DONE never write.
    assign wr_en_c   = cke && bus.spu_m_valid && (wr_cnt_q < len_q) &&
                       ((state_q == ST_READ) || (state_q == ST_DRAIN));
    assign last_wr   = wr_en_c && ((wr_cnt_q + LEN_BITS'(1)) == len_q);

    spu_valid_delay #(.DEPTH(RD_LATENCY)) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .clr   (start_acc),
        .din   (rd_en_c),
        .dout  (dly_out)
    );

    // State and pass-context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_idx_q <= '0;
            wr_cnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_idx_q <= rd_idx_d;
            wr_cnt_q <= wr_cnt_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; everything holds while cke is low. A final write wins over abort.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_idx_d = rd_idx_q;
        wr_cnt_d = wr_cnt_q;
        cnt_d    = cnt_q;
        if (cke) begin
            if (wr_en_c) wr_cnt_d = wr_cnt_q + LEN_BITS'(1);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_d    = cfg_src_addr;
                        dst_d    = cfg_dst_addr;
                        len_d    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
                        rd_idx_d = '0;
                        wr_cnt_d = '0;
                        cnt_d    = '0;
                        err_d    = ERR_NONE;
                        state_d  = (cfg_len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_wr) begin
                        state_d = ST_DONE;
                    end else if (abort) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                        err_d   = ERR_ABORT;
                    end else begin
                        rd_idx_d = rd_idx_q + LEN_BITS'(1);
                        if (rd_idx_q == (len_q - LEN_BITS'(1))) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_wr) begin
                        state_d = ST_DONE;
                    end else if (abort) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                        err_d   = ERR_ABORT;
                    end else if (cnt_q == TO_LAST) begin
                        // DONE lands exactly TO_BOUND cycles after DRAIN entry.
                        state_d = ST_DONE;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == FL_LAST) state_d = ST_DONE;
                    else                  cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs; every strobe is qualified by cke.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
        error           = err_q;
        wr_count        = wr_cnt_q;
        bus.rd_en       = rd_en_c;
        bus.rd_addr     = src_q + rd_idx_q[ADDR_BITS-1:0];
        bus.spu_s_valid = cke && dly_out;
        bus.wr_en       = wr_en_c;
        bus.wr_addr     = dst_q + wr_cnt_q[ADDR_BITS-1:0];
    end
endmodule

// File: tb/tb_spu_stream_sequencer.sv
// Bench for spu_stream_sequencer: SPU delay-line model, event monitor and
// per-scenario tasks comparing recorded events against spec-derived timing.
module tb_spu_stream_sequencer;
    localparam int SPL = 256;
    localparam int LAT = 1 + SPL;        // RD_LATENCY + SPU_LATENCY
    localparam int TO  = 1 + SPL + 16;   // drain timeout bound

    logic        clk = 1'b0;
    logic        reset, cke, start, abort, stray;
    logic [9:0]  cfg_src_addr, cfg_dst_addr;
    logic [10:0] cfg_len;
    logic        busy, done;
    logic [1:0]  error;
    logic [10:0] wr_count;

    int ncmp = 0;
    int nfail = 0;

    spu_stream_sequencer_if #(.ADDR_BITS(10)) bus ();

    spu_stream_sequencer #(
        .ADDR_BITS(10), .LEN_BITS(11), .RD_LATENCY(1),
        .SPU_LATENCY(SPL), .TIMEOUT_MARGIN(16)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke), .start(start), .abort(abort),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_len(cfg_len),
        .busy(busy), .done(done), .error(error), .wr_count(wr_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // SPU model: fixed-latency valid pipe advancing on cke, with optional drop of one input.
    logic [SPL-1:0] pipe;
    int sv_cnt  = 0;
    int drop_at = -1;
    always @(posedge clk or posedge reset) begin
        if (reset) pipe <= '0;
        else if (cke) begin
            pipe <= {pipe[SPL-2:0], bus.spu_s_valid && (sv_cnt != drop_at)};
            if (bus.spu_s_valid) sv_cnt <= sv_cnt + 1;
        end
    end
    assign bus.spu_m_valid = pipe[SPL-1] | stray;

    // Event monitor: records strobes with their cke-cycle index.
    int ccyc = 0, start_cyc = 0, last_done_cyc = -1, done_cnt = 0, busy_cnt = 0, strobe_viol = 0;
    int rd_cyc_q[$], rd_addr_q[$], wr_cyc_q[$], wr_addr_q[$];
    always @(negedge clk) begin
        #1;
        if (cke) begin
            if (start && !busy) start_cyc = ccyc;
            if (bus.rd_en) begin rd_cyc_q.push_back(ccyc); rd_addr_q.push_back(int'(bus.rd_addr)); end
            if (bus.wr_en) begin wr_cyc_q.push_back(ccyc); wr_addr_q.push_back(int'(bus.wr_addr)); end
            if (done) begin done_cnt++; last_done_cyc = ccyc; end
            if (busy) busy_cnt++;
            ccyc++;
        end else if (bus.rd_en || bus.wr_en || bus.spu_s_valid) begin
            strobe_viol++;
        end
    end

    // Drives one pass. cke_mode: 0 always on, 1 toggling 1/0, 2 random.
    task automatic run_job(input int src, input int dst, input int len, input int cke_mode,
                           input int abort_at, input int restart_at, input int budget,
                           output bit finished);
        int rel, n;
        n = done_cnt;
        rel = 0;
        finished = 1'b0;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (c == 0) begin
                cke = 1'b1; start = 1'b1;
                cfg_src_addr = 10'(src); cfg_dst_addr = 10'(dst); cfg_len = 11'(len);
            end else begin
                case (cke_mode)
                    0:       cke = 1'b1;
                    1:       cke = ((c % 2) == 0);
                    default: cke = ($urandom_range(0, 3) != 0);
                endcase
                if (rel == abort_at) begin cke = 1'b1; abort = 1'b1; end
                if (rel == restart_at) begin
                    cke = 1'b1; start = 1'b1;
                    cfg_src_addr = ~cfg_src_addr; cfg_len = 11'd3;
                end
            end
            #2;
            if (done_cnt != n) finished = 1'b1;
            if (cke) rel++;
        end
        @(negedge clk); start = 1'b0; abort = 1'b0; cke = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cke = 1'b0; start = 1'b0; abort = 1'b0; stray = 1'b0;
        cfg_src_addr = '0; cfg_dst_addr = '0; cfg_len = '0;
        repeat (2) @(negedge clk);
        #2;
        ncmp++;
        if ({busy, done, error, wr_count, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.spu_s_valid} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%0d wc=%0d rd=%b/%h wr=%b/%h sv=%b, expected all 0",
                     busy, done, error, wr_count, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.spu_s_valid);
        end
        @(negedge clk); reset = 1'b0; cke = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int rb, wb, dn; bit fin;
        rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); dn = done_cnt;
        run_job('h010, 'h200, 4, 0, -1, -1, 400, fin);
        ncmp++; if (fin !== 1'b1) begin nfail++; $display("FAIL basic_finish: got %0d expected 1", fin); end
        ncmp++;
        if (rd_cyc_q.size() - rb != 4 || wr_cyc_q.size() - wb != 4) begin
            nfail++; $display("FAIL basic_counts: got rd=%0d wr=%0d expected 4/4", rd_cyc_q.size() - rb, wr_cyc_q.size() - wb);
        end
        for (int i = 0; i < 4 && rb + i < rd_cyc_q.size() && wb + i < wr_cyc_q.size(); i++) begin
            ncmp++;
            if (rd_addr_q[rb+i] != 'h010 + i || rd_cyc_q[rb+i] != start_cyc + 1 + i ||
                wr_addr_q[wb+i] != 'h200 + i || wr_cyc_q[wb+i] != start_cyc + 1 + i + LAT) begin
                nfail++;
                $display("FAIL basic_beat%0d: got rd %h@%0d wr %h@%0d expected rd %h@%0d wr %h@%0d", i,
                         rd_addr_q[rb+i], rd_cyc_q[rb+i], wr_addr_q[wb+i], wr_cyc_q[wb+i],
                         'h010 + i, start_cyc + 1 + i, 'h200 + i, start_cyc + 1 + i + LAT);
            end
        end
        ncmp++;
        if (last_done_cyc != start_cyc + 4 + LAT + 1 || done_cnt - dn != 1) begin
            nfail++; $display("FAIL basic_done: got cyc %0d pulses %0d expected cyc %0d pulses 1",
                              last_done_cyc, done_cnt - dn, start_cyc + 4 + LAT + 1);
        end
        ncmp++;
        if (error !== 2'd0 || wr_count !== 11'd4) begin
            nfail++; $display("FAIL basic_status: got err=%0d wc=%0d expected err=0 wc=4", error, wr_count);
        end
    endtask

    task automatic test_zero_len();
        int rb, wb, bb; bit fin;
        rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); bb = busy_cnt;
        run_job('h123, 'h045, 0, 0, -1, -1, 20, fin);
        ncmp++;
        if (fin !== 1'b1 || last_done_cyc != start_cyc + 1) begin
            nfail++; $display("FAIL zero_done: got fin=%0d cyc %0d expected fin=1 cyc %0d", fin, last_done_cyc, start_cyc + 1);
        end
        ncmp++;
        if (rd_cyc_q.size() != rb || wr_cyc_q.size() != wb || busy_cnt - bb != 1) begin
            nfail++; $display("FAIL zero_strobes: got rd=%0d wr=%0d busy=%0d expected 0/0/1",
                              rd_cyc_q.size() - rb, wr_cyc_q.size() - wb, busy_cnt - bb);
        end
    endtask

    task automatic test_wrap_cke();
        int rb, wb, sv; bit fin;
        rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); sv = strobe_viol;
        run_job('h3FE, 'h3FD, 4, 1, -1, -1, 800, fin);
        ncmp++;
        if (fin !== 1'b1 || rd_cyc_q.size() - rb != 4 || wr_cyc_q.size() - wb != 4) begin
            nfail++; $display("FAIL wrap_counts: got fin=%0d rd=%0d wr=%0d expected 1/4/4", fin, rd_cyc_q.size() - rb, wr_cyc_q.size() - wb);
        end
        for (int i = 0; i < 4 && rb + i < rd_cyc_q.size() && wb + i < wr_cyc_q.size(); i++) begin
            ncmp++;
            if (rd_addr_q[rb+i] != ('h3FE + i) % 1024 || wr_addr_q[wb+i] != ('h3FD + i) % 1024 ||
                rd_cyc_q[rb+i] != start_cyc + 1 + i) begin
                nfail++; $display("FAIL wrap_beat%0d: got rd %h@%0d wr %h expected rd %h@%0d wr %h", i,
                                  rd_addr_q[rb+i], rd_cyc_q[rb+i], wr_addr_q[wb+i],
                                  ('h3FE + i) % 1024, start_cyc + 1 + i, ('h3FD + i) % 1024);
            end
        end
        ncmp++;
        if (strobe_viol != sv || last_done_cyc != start_cyc + 4 + LAT + 1) begin
            nfail++; $display("FAIL wrap_gating: got viol=%0d done %0d expected viol=0 done %0d",
                              strobe_viol - sv, last_done_cyc, start_cyc + 4 + LAT + 1);
        end
    endtask

    task automatic test_timeout();
        int wb; bit fin;
        wb = wr_cyc_q.size();
        drop_at = sv_cnt + int'($urandom_range(0, 7));
        run_job('h050, 'h150, 8, 0, -1, -1, 500, fin);
        drop_at = -1;
        ncmp++;
        if (wr_count !== 11'd7 || wr_cyc_q.size() - wb != 7) begin
            nfail++; $display("FAIL timeout_count: got wc=%0d writes=%0d expected 7", wr_count, wr_cyc_q.size() - wb);
        end
        ncmp++;
        if (fin !== 1'b1 || error !== 2'd1 || last_done_cyc != start_cyc + 8 + 1 + TO) begin
            nfail++; $display("FAIL timeout_done: got fin=%0d err=%0d cyc %0d expected 1/1/%0d",
                              fin, error, last_done_cyc, start_cyc + 8 + 1 + TO);
        end
    endtask

    task automatic test_abort();
        int rb, wb; bit fin;
        rb = rd_cyc_q.size(); wb = wr_cyc_q.size();
        run_job('h080, 'h180, 16, 0, 3, -1, 500, fin);
        ncmp++;
        if (rd_cyc_q.size() - rb != 3 || wr_cyc_q.size() != wb) begin
            nfail++; $display("FAIL abort_strobes: got rd=%0d wr=%0d expected 3/0", rd_cyc_q.size() - rb, wr_cyc_q.size() - wb);
        end
        ncmp++;
        if (fin !== 1'b1 || error !== 2'd2 || last_done_cyc != start_cyc + 3 + 1 + LAT) begin
            nfail++; $display("FAIL abort_done: got fin=%0d err=%0d cyc %0d expected 1/2/%0d",
                              fin, error, last_done_cyc, start_cyc + 3 + 1 + LAT);
        end
        wb = wr_cyc_q.size();
        run_job('h090, 'h190, 1, 0, -1, -1, 400, fin);
        ncmp++;
        if (fin !== 1'b1 || error !== 2'd0 || wr_cyc_q.size() - wb != 1) begin
            nfail++; $display("FAIL abort_restart: got fin=%0d err=%0d wr=%0d expected 1/0/1", fin, error, wr_cyc_q.size() - wb);
        end
    endtask

    task automatic test_abort_final_write();
        int wb; bit fin;
        wb = wr_cyc_q.size();
        run_job('h011, 'h211, 5, 0, 5 + LAT, -1, 400, fin);
        ncmp++;
        if (fin !== 1'b1 || error !== 2'd0 || wr_count !== 11'd5 || last_done_cyc != start_cyc + 5 + LAT + 1) begin
            nfail++; $display("FAIL abort_final: got fin=%0d err=%0d wc=%0d cyc %0d expected 1/0/5/%0d",
                              fin, error, wr_count, last_done_cyc, start_cyc + 5 + LAT + 1);
        end
    endtask

    task automatic test_clamp();
        int rb; bit fin; int src;
        src = int'($urandom_range(0, 1023));
        rb = rd_cyc_q.size();
        run_job(src, 'h000, 'h7FF, 0, -1, -1, 1500, fin);
        ncmp++;
        if (fin !== 1'b1 || rd_cyc_q.size() - rb != 1024 || wr_count !== 11'd1024) begin
            nfail++; $display("FAIL clamp_count: got fin=%0d rd=%0d wc=%0d expected 1/1024/1024", fin, rd_cyc_q.size() - rb, wr_count);
        end
        ncmp++;
        if (rd_cyc_q.size() - rb == 1024 && (rd_addr_q[rb+1023] != (src + 1023) % 1024 || last_done_cyc != start_cyc + 1024 + LAT + 1)) begin
            nfail++; $display("FAIL clamp_end: got last %h done %0d expected %h done %0d",
                              rd_addr_q[rb+1023], last_done_cyc, (src + 1023) % 1024, start_cyc + 1024 + LAT + 1);
        end
    endtask

    task automatic test_start_busy();
        int rb; bit fin;
        rb = rd_cyc_q.size();
        run_job('h2A0, 'h0A0, 6, 0, -1, 2, 400, fin);
        ncmp++;
        if (fin !== 1'b1 || rd_cyc_q.size() - rb != 6 || last_done_cyc != start_cyc + 6 + LAT + 1) begin
            nfail++; $display("FAIL busy_start_count: got fin=%0d rd=%0d done %0d expected 1/6/%0d",
                              fin, rd_cyc_q.size() - rb, last_done_cyc, start_cyc + 6 + LAT + 1);
        end
        for (int i = 0; i < 6 && rb + i < rd_cyc_q.size(); i++) begin
            ncmp++;
            if (rd_addr_q[rb+i] != 'h2A0 + i) begin
                nfail++; $display("FAIL busy_start_addr%0d: got %h expected %h", i, rd_addr_q[rb+i], 'h2A0 + i);
            end
        end
    endtask

    task automatic test_stray();
        int wb;
        wb = wr_cyc_q.size();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); cke = 1'b1; stray = 1'b1;
        end
        @(negedge clk); stray = 1'b0;
        @(negedge clk);
        ncmp++;
        if (wr_cyc_q.size() != wb || wr_count !== 11'd6) begin
            nfail++; $display("FAIL stray_idle: got writes=%0d wc=%0d expected 0/6", wr_cyc_q.size() - wb, wr_count);
        end
    endtask

    task automatic test_random();
        int rb, wb, sv, src, dst, len; bit fin;
        for (int it = 0; it < 4; it++) begin
            src = int'($urandom_range(0, 1023)); dst = int'($urandom_range(0, 1023)); len = int'($urandom_range(1, 24));
            rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); sv = strobe_viol;
            run_job(src, dst, len, 2, -1, -1, 2000, fin);
            ncmp++;
            if (fin !== 1'b1 || rd_cyc_q.size() - rb != len || wr_cyc_q.size() - wb != len || strobe_viol != sv) begin
                nfail++; $display("FAIL rand%0d_counts: got fin=%0d rd=%0d wr=%0d viol=%0d expected 1/%0d/%0d/0",
                                  it, fin, rd_cyc_q.size() - rb, wr_cyc_q.size() - wb, strobe_viol - sv, len, len);
            end
            for (int i = 0; i < len && rb + i < rd_cyc_q.size() && wb + i < wr_cyc_q.size(); i++) begin
                ncmp++;
                if (rd_addr_q[rb+i] != (src + i) % 1024 || rd_cyc_q[rb+i] != start_cyc + 1 + i ||
                    wr_addr_q[wb+i] != (dst + i) % 1024 || wr_cyc_q[wb+i] != start_cyc + 1 + i + LAT) begin
                    nfail++; $display("FAIL rand%0d_beat%0d: got rd %h@%0d wr %h@%0d expected rd %h@%0d wr %h@%0d", it, i,
                                      rd_addr_q[rb+i], rd_cyc_q[rb+i], wr_addr_q[wb+i], wr_cyc_q[wb+i],
                                      (src + i) % 1024, start_cyc + 1 + i, (dst + i) % 1024, start_cyc + 1 + i + LAT);
                end
            end
            ncmp++;
            if (last_done_cyc != start_cyc + len + LAT + 1 || error !== 2'd0 || wr_count !== 11'(len)) begin
                nfail++; $display("FAIL rand%0d_done: got cyc %0d err=%0d wc=%0d expected %0d/0/%0d",
                                  it, last_done_cyc, error, wr_count, start_cyc + len + LAT + 1, len);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cke = 1'b1; start = 1'b1; cfg_src_addr = 10'h0C0; cfg_dst_addr = 10'h1C0; cfg_len = 11'd4;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        ncmp++;
        if (busy !== 1'b1) begin nfail++; $display("FAIL midreset_busy: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        ncmp++;
        if ({busy, done, error, wr_count, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.spu_s_valid} !== '0) begin
            nfail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%0d wc=%0d rd=%b/%h wr=%b/%h sv=%b, expected all 0",
                     busy, done, error, wr_count, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.spu_s_valid);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap_cke();
        test_timeout();
        test_abort();
        test_abort_final_write();
        test_start_busy();
        test_stray();
        test_random();
        test_clamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/spu_stream_sequencer.md
Name: spu_stream_sequencer

Overview:
Control-only sequencer that runs one SRAM-to-SRAM pass through the stream processing unit (SPU). It issues source SRAM reads and drives the SPU input valid, aligned to the SRAM read latency. It counts SPU output valids into destination write addresses and reports done or an error code. The SPU has no backpressure, so the shared cke is the only stall. Data buses connect SRAM to SPU to SRAM outside this block.

Parameters:
ADDR_BITS, 10, SRAM word address width
LEN_BITS, 11, transfer length width (ADDR_BITS+1)
RD_LATENCY, 1, source SRAM read latency in cke cycles (>=1)
SPU_LATENCY, 256, SPU s_valid-to-m_valid latency in cke cycles
TIMEOUT_MARGIN, 16, extra drain cycles allowed before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cke  in  1  clock enable, shared with the SPU
start  in  1  start pulse, accepted only in IDLE
abort  in  1  abort request
cfg_src_addr  in  ADDR_BITS  source base address
cfg_dst_addr  in  ADDR_BITS  destination base address
cfg_len  in  LEN_BITS  word count; 0 is allowed
busy  out  1  high while not IDLE
done  out  1  one-cycle completion pulse
error  out  2  0 ok, 1 timeout, 2 aborted; holds until the next accepted start
rd_en  out  1  source read strobe
rd_addr  out  ADDR_BITS  source read address
spu_s_valid  out  1  SPU input valid
spu_m_valid  in  1  SPU output valid
wr_en  out  1  destination write strobe
wr_addr  out  ADDR_BITS  destination write address
wr_count  out  LEN_BITS  words written in the current pass

Behaviour:
- Reset (asynchronous): all outputs and registers are 0; state is IDLE.
- cke=0: all state holds; rd_en, wr_en and spu_s_valid are forced to 0, since every strobe is ANDed with cke. spu_m_valid is sampled only when cke=1. All cycle counts below are cke=1 cycles.
- States: IDLE, READ, DRAIN, FLUSH, DONE.
- IDLE:
  - start=1 latches the config, clears error and wr_count.
  - cfg_len is clamped to 2^ADDR_BITS.
  - Goes to READ, or to DONE if len=0.
- READ:
  - rd_en=1 every cycle; rd_addr = src + i (mod 2^ADDR_BITS), i = 0..len-1.
  - The first rd_en is the cycle after start is accepted.
  - After the last issue, goes to DRAIN.
- spu_s_valid is rd_en delayed by exactly RD_LATENCY cycles through a cke-gated shift register. The shift register is cleared on reset and on start.
- Writes:
  - wr_en = spu_m_valid and (state is READ or DRAIN) and wr_count < len. This path is combinational from spu_m_valid.
  - wr_addr = dst + wr_count (mod 2^ADDR_BITS).
  - wr_count increments on each wr_en.
- DRAIN:
  - A cycle counter starts at 0 when DRAIN is entered.
  - When wr_count reaches len, go to DONE.
  - If the counter reaches RD_LATENCY+SPU_LATENCY+TIMEOUT_MARGIN first, set error=1 and go to DONE.
- abort=1 in READ or DRAIN:
  - Stop issuing reads and set error=2.
  - Go to FLUSH for RD_LATENCY+SPU_LATENCY cycles with wr_en suppressed, so in-flight results are discarded and the SPU pipeline is empty.
  - Then go to DONE.
- abort in IDLE or DONE is ignored.
- Simultaneous events:
  - If abort and the final wr_en occur in the same cycle, the write completes, error stays 0, and the next state is DONE.
  - start while busy is ignored.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Stray spu_m_valid in IDLE, FLUSH or DONE never causes a write.
- Nominal timing: for len=N with start accepted at T, the last wr_en is at T+N+RD_LATENCY+SPU_LATENCY and done is at T+N+RD_LATENCY+SPU_LATENCY+1.

Decomposition:
- Package spu_seq_pkg holds:
  - the state enum (IDLE, READ, DRAIN, FLUSH, DONE);
  - the error code enum (ERR_NONE=0, ERR_TIMEOUT=1, ERR_ABORT=2);
  - a helper function computing the timeout/flush bound width.
- One sub-module, spu_valid_delay (parameter DEPTH), implements the cke-gated, start-clearable valid delay line used for spu_s_valid.

Test Plan:
- Basic pass. Stimulus: RD_LATENCY=1, bench SPU model delays valid by 256, start src=0x010 dst=0x200 len=4. Required: rd_addr 0x010..0x013 on consecutive cycles; wr_addr 0x200..0x203; done one cycle after the last write; error=0; wr_count=4.
- Zero length. Stimulus: len=0. Required: done one cycle after start; no rd_en or wr_en; busy high for exactly one cycle.
- Address wrap and cke. Stimulus: src=0x3FE len=4 with cke toggling 1,0 repeatedly. Required: rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; no strobe in any cke=0 cycle; done after 4 writes.
- Timeout. Stimulus: SPU model drops one of 8 m_valids. Required: wr_count=7; error=1 and done exactly 1+256+16 cke cycles after entering DRAIN.
- Abort. Stimulus: abort in the 3rd READ cycle of len=16. Required: rd_en stops the next cycle; no wr_en for the following 257 cycles; then done with error=2. A new start clears error to 0.
- Reset mid-operation. Stimulus: assert reset during DRAIN. Required: all outputs 0 immediately (asynchronous). Stimulus: start while busy. Required: ignored, rd_addr sequence unaffected.
